axi4_rd_arbiter: RTL and testbench

Two-master AXI4-Lite read-channel arbiter placed in front of the AXI4 test memory. Shares one read address/data channel between the instruction-fetch requester (M0) and the data-load requester (M1). Round-robin grant, one outstanding transaction. Drives `arprot` so the memory's instruction/data distinction (`arprot[2]`) reflects the granted requester.

---
 rtl/axi4_pkg.sv | 16 +
 rtl/axi4_rd_arbiter_if.sv | 19 +
 rtl/rr_arb2.sv | 25 ++
 rtl/axi4_rd_arbiter.sv | 136 +++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4-Lite read-arbiter types: FSM state encoding plus response and protection constants.
package axi4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_PROT_INSN = 3'b100;
  localparam logic [2:0] AXI_PROT_DATA = 3'b000;

endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// AXI4-Lite read address/data channel bundle; master drives the request side, slave answers it.
interface axi4_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (output arvalid, araddr, arprot, rready,
                  input  arready, rvalid, rdata, rresp);
  modport slave  (input  arvalid, araddr, arprot, rready,
                  output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: combinational one-hot grant, registered tie-break bit (M0 after reset).
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,   // a transaction owned by last_m1 just completed
  input  logic       last_m1,
  output logic [1:0] gnt
);

  logic prio_m1_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_m1_q ? 2'b10 : 2'b01;
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     prio_m1_q <= 1'b0;
    else if (update) prio_m1_q <= ~last_m1;
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter (M0 = fetch, M1 = load), one outstanding transaction.
// Optional DATA-phase watchdog returning SLVERR is enabled by defining AXI_RD_ARB_TIMEOUT_EN.
module axi4_rd_arbiter
  import axi4_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  axi4_rd_arbiter_if.slave         m0,
  axi4_rd_arbiter_if.slave         m1,
  axi4_rd_arbiter_if.master        s,
  output logic                     grant_insn
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4_rd_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  rd_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arprot_q;
  logic              gnt_m1_q;
  logic              grant_insn_q;
  logic [1:0]        req, pick;
  logic              done;
  logic              r_valid, r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              tmo;

  // Gating with resetn keeps arready low while reset is held, even though it is combinational.
  assign req = {m1.arvalid, m0.arvalid} & {2{resetn}};

  rr_arb2 u_rr (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .update  (done),
    .last_m1 (gnt_m1_q),
    .gnt     (pick)
  );

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (RAW_W < 8) ? 8 : RAW_W;

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counts completed DATA cycles; the response is forced in DATA cycle number TIMEOUT_CYCLES.
  assign tmo = (state_q == DATA) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               tmo_cnt_q <= '0;
    else if (state_q != DATA)  tmo_cnt_q <= '0;
    else if (!tmo)             tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    r_valid    = 1'b0;
    r_ready    = 1'b0;
    r_data     = '0;
    r_resp     = AXI_RESP_OKAY;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        m0.arready = pick[0];
        m1.arready = pick[1];
        if (|pick) state_d = ADDR;
      end
      ADDR: begin
        s.arvalid = 1'b1;
        if (s.arready) state_d = DATA;
      end
      DATA: begin
        r_ready = gnt_m1_q ? m1.rready : m0.rready;
        if (tmo) begin
          // Synthesised error response; the downstream side is not handshaken.
          r_valid = 1'b1;
          r_resp  = AXI_RESP_SLVERR;
          done    = r_ready;
        end else begin
          r_valid  = s.rvalid;
          r_data   = s.rdata;
          r_resp   = s.rresp;
          s.rready = r_ready;
          done     = s.rvalid & r_ready;
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arprot_q     <= AXI_PROT_DATA;
      gnt_m1_q     <= 1'b0;
      grant_insn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |pick) begin
        araddr_q     <= pick[1] ? m1.araddr : m0.araddr;
        arprot_q     <= pick[1] ? AXI_PROT_DATA : AXI_PROT_INSN;
        gnt_m1_q     <= pick[1];
        grant_insn_q <= pick[0];
      end else if (done) begin
        grant_insn_q <= 1'b0;
      end
    end
  end

  assign s.araddr   = araddr_q;
  assign s.arprot   = arprot_q;
  assign grant_insn = grant_insn_q;

  assign m0.rvalid = r_valid & ~gnt_m1_q;
  assign m1.rvalid = r_valid &  gnt_m1_q;
  assign m0.rdata  = m0.rvalid ? r_data : '0;
  assign m1.rdata  = m1.rvalid ? r_data : '0;
  assign m0.rresp  = m0.rvalid ? r_resp : 2'b00;
  assign m1.rresp  = m1.rvalid ? r_resp : 2'b00;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench for axi4_rd_arbiter: directed plus randomized transactions against a
// transaction-level model of the round-robin rule (tie goes to the requester not served last).
module tb_axi4_rd_arbiter;

  logic clk;
  logic resetn;
  logic grant_insn;

  int checks = 0;
  int errors = 0;
  int prio   = 0;          // requester that wins when both ask
  int obs_gnt[$];          // requester actually granted, as seen on arready

  axi4_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  axi4_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  axi4_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  axi4_rd_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .grant_insn (grant_insn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_arvalid"}, s_if.arvalid, 0);
    check({tag, "_s_araddr"},  s_if.araddr, 0);
    check({tag, "_s_arprot"},  s_if.arprot, 0);
    check({tag, "_s_rready"},  s_if.rready, 0);
    check({tag, "_m0_arready"}, m0_if.arready, 0);
    check({tag, "_m1_arready"}, m1_if.arready, 0);
    check({tag, "_m0_rvalid"}, m0_if.rvalid, 0);
    check({tag, "_m1_rvalid"}, m1_if.rvalid, 0);
    check({tag, "_m0_rdata"},  m0_if.rdata, 0);
    check({tag, "_m1_rdata"},  m1_if.rdata, 0);
    check({tag, "_m0_rresp"},  m0_if.rresp, 0);
    check({tag, "_m1_rresp"},  m1_if.rresp, 0);
    check({tag, "_grant_insn"}, grant_insn, 0);
  endtask

  // One full transaction starting in IDLE; ar_dly cycles of s_arready low, r_dly cycles of
  // the winner's rready low while s_rvalid is high.
  task automatic run_txn(input logic req0, input logic req1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input int ar_dly, input int r_dly,
                         input logic [31:0] data, input logic [1:0] resp);
    int          w;
    logic [31:0] exp_addr;
    logic [2:0]  exp_prot;
    w        = (req0 && req1) ? prio : (req0 ? 0 : 1);
    exp_addr = (w == 0) ? a0 : a1;
    exp_prot = (w == 0) ? 3'b100 : 3'b000;

    m0_if.arvalid = req0;  m0_if.araddr = a0;
    m1_if.arvalid = req1;  m1_if.araddr = a1;
    #4;
    check("grant_m0_arready", m0_if.arready, w == 0);
    check("grant_m1_arready", m1_if.arready, w == 1);
    check("grant_s_arvalid", s_if.arvalid, 0);
    obs_gnt.push_back(m1_if.arready ? 1 : 0);
    next_cycle();

    // Requesters withdraw and scramble their address: the captured one must persist.
    m0_if.arvalid = 1'b0;  m0_if.araddr = ~a0;
    m1_if.arvalid = 1'b0;  m1_if.araddr = ~a1;
    for (int i = 0; i <= ar_dly; i++) begin
      s_if.arready = (i == ar_dly);
      #4;
      check("addr_s_arvalid", s_if.arvalid, 1);
      check("addr_s_araddr", s_if.araddr, exp_addr);
      check("addr_s_arprot", s_if.arprot, exp_prot);
      check("addr_grant_insn", grant_insn, w == 0);
      check("addr_m0_arready", m0_if.arready, 0);
      check("addr_m1_arready", m1_if.arready, 0);
      check("addr_m0_rvalid", m0_if.rvalid, 0);
      check("addr_m1_rvalid", m1_if.rvalid, 0);
      next_cycle();
    end
    s_if.arready = 1'b0;

    s_if.rvalid = 1'b1;  s_if.rdata = data;  s_if.rresp = resp;
    for (int i = 0; i <= r_dly; i++) begin
      // The loser's rready is held high to prove it is ignored.
      m0_if.rready = (w == 0) ? (i == r_dly) : 1'b1;
      m1_if.rready = (w == 1) ? (i == r_dly) : 1'b1;
      #4;
      check("data_s_rready", s_if.rready, i == r_dly);
      check("data_s_arvalid", s_if.arvalid, 0);
      check("data_grant_insn", grant_insn, w == 0);
      if (w == 0) begin
        check("data_m0_rvalid", m0_if.rvalid, 1);
        check("data_m0_rdata", m0_if.rdata, data);
        check("data_m0_rresp", m0_if.rresp, resp);
        check("data_m1_rvalid", m1_if.rvalid, 0);
        check("data_m1_rdata", m1_if.rdata, 0);
      end else begin
        check("data_m1_rvalid", m1_if.rvalid, 1);
        check("data_m1_rdata", m1_if.rdata, data);
        check("data_m1_rresp", m1_if.rresp, resp);
        check("data_m0_rvalid", m0_if.rvalid, 0);
        check("data_m0_rdata", m0_if.rdata, 0);
      end
      next_cycle();
    end
    s_if.rvalid = 1'b0;  s_if.rdata = '0;  s_if.rresp = 2'b00;
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    prio = 1 - w;
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};

    resetn = 1'b0;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h1234; m0_if.arprot = 3'b000; m0_if.rready = 1'b1;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h5678; m1_if.arprot = 3'b000; m1_if.rready = 1'b1;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; s_if.rdata = 32'hFFFF_FFFF; s_if.rresp = 2'b11;
    #2;
    check_all_zero("reset");
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0; m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;
    next_cycle();
    resetn = 1'b1;

    // Idle with nobody requesting stays idle.
    for (int i = 0; i < 2; i++) begin
      #4;
      check("idle_s_arvalid", s_if.arvalid, 0);
      check("idle_m0_arready", m0_if.arready, 0);
      next_cycle();
    end

    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 2'b00);
    run_txn(1'b0, 1'b1, 32'h0, 32'h2000, 5, 0, 32'h0BAD_F00D, 2'b00);

    obs_gnt.delete();
    for (int t = 0; t < 4; t++)
      run_txn(1'b1, 1'b1, 32'h1000 + 32'(t * 4), 32'h8000 + 32'(t * 4), 0, 0, $urandom, 2'b00);
    for (int t = 0; t < 4; t++)
      check("simul_order", obs_gnt[t], exp_order[t]);

    run_txn(1'b0, 1'b1, 32'h0, 32'h40, 0, 3, 32'hCAFE_0001, 2'b01);

    // Reset in DATA: priority was M1 beforehand, must revert to M0.
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 0, 0, 32'h1111_2222, 2'b00);
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h3000;
    next_cycle();
    m1_if.arvalid = 1'b0; s_if.arready = 1'b1;
    next_cycle();
    s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rdata = 32'h5555_AAAA; s_if.rresp = 2'b10;
    #2;
    check("pre_reset_m1_rvalid", m1_if.rvalid, 1);
    resetn = 1'b0;
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    #1;
    check_all_zero("midreset");
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0; m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;
    next_cycle();
    resetn = 1'b1;
    prio = 0;
    obs_gnt.delete();
    run_txn(1'b1, 1'b1, 32'h400, 32'h500, 0, 0, 32'h7777_8888, 2'b00);
    check("post_reset_first_grant", obs_gnt[0], 0);

`ifdef AXI_RD_ARB_TIMEOUT_EN
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h600;
    next_cycle();
    m0_if.arvalid = 1'b0; s_if.arready = 1'b1;
    next_cycle();
    s_if.arready = 1'b0; m0_if.rready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      #4;
      check("tmo_m0_rvalid", m0_if.rvalid, c == 16);
      check("tmo_s_rready", s_if.rready, c != 16);
      if (c == 16) begin
        check("tmo_m0_rresp", m0_if.rresp, 2'b10);
        check("tmo_m0_rdata", m0_if.rdata, 0);
      end
      next_cycle();
    end
    m0_if.rready = 1'b0;
    prio = 1;
    #4;
    check("tmo_idle_grant_insn", grant_insn, 0);
    check("tmo_idle_s_arvalid", s_if.arvalid, 0);
    next_cycle();
`endif

    for (int t = 0; t < 16; t++) begin
      int r;
      r = $urandom_range(1, 3);
      run_txn(r[0], r[1], $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
